// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the handshaked sequential ALU.
//   alu_op_e    : 4-bit operation code (12..15 reserved)
//   alu_flags_t : registered result flags
//   alu_state_e : control FSM states
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOR  = 4'd5,
      OP_SLT  = 4'd6,
      OP_SLTU = 4'd7,
      OP_SLL  = 4'd8,
      OP_SRL  = 4'd9,
      OP_SRA  = 4'd10,
      OP_MUL  = 4'd11
   } alu_op_e;

   typedef struct packed {
      logic zero;
      logic negative;
      logic carryout;
      logic overflow;
   } alu_flags_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL_RUN,
      ST_DONE
   } alu_state_e;

   // Highest defined op code; anything above is reserved.
   localparam logic [3:0] OP_LAST_DEFINED = 4'd11;

   function automatic logic is_reserved(input logic [3:0] code);
      return code > OP_LAST_DEFINED;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add unsigned multiplier, one multiplier
// bit per cycle, WIDTH cycles per product.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and begin (ignored while busy)
//   a, b       : multiplicand / multiplier, sampled on start
//   busy       : iteration in progress
//   done       : final iteration this cycle; product is valid now
//   product    : full 2*WIDTH-bit product
module alu_mul_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   import alu_pkg::*;

   localparam int unsigned CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d;

   // The last bit is folded in combinationally so the product is
   // available in the same cycle as done, not one cycle later.
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (busy_q) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end else if (start) begin
         mcand_d  = {{WIDTH{1'b0}}, a};
         acc_d    = '0;
         mplier_d = b;
         cnt_d    = CW'(WIDTH - 1);
         busy_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign done    = busy_q && (cnt_q == '0);
   assign product = acc_step;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and flags.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : operand-side handshake (op, bus_a, bus_b)
//   op                         : alu_pkg::alu_op_e code, 12..15 reserved
//   bus_a, bus_b               : operands; shift amount is bus_b low bits
//   out_valid/out_ready        : result-side handshake
//   out                        : registered result
//   zero/negative/carryout/overflow : registered flags, paired with out
module alu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] bus_a,
   input  logic [WIDTH-1:0] bus_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             negative,
   output logic             carryout,
   output logic             overflow
);
   import alu_pkg::*;

   localparam int unsigned SW = $clog2(WIDTH);

   alu_op_e            op_e;
   alu_state_e         state_q, state_d;
   logic [WIDTH-1:0]   out_q, out_d;
   alu_flags_t         flags_q, flags_d;

   logic [WIDTH:0]     sum_w;
   logic [WIDTH-1:0]   b_eff;
   logic               is_sub;
   logic [SW-1:0]      shamt;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_v;

   logic               ready_c, take_single, take_mul, mul_start;
   logic               mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_product;

   assign op_e  = alu_op_e'(op);
   assign shamt = bus_b[SW-1:0];

   // Single-cycle datapath; SUB shares the adder as A + ~B + 1.
   always_comb begin
      is_sub  = (op_e == OP_SUB);
      b_eff   = is_sub ? ~bus_b : bus_b;
      sum_w   = {1'b0, bus_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      if (!is_reserved(op)) begin
         case (op_e)
            OP_ADD, OP_SUB: begin
               alu_res = sum_w[WIDTH-1:0];
               alu_c   = sum_w[WIDTH];
               alu_v   = (bus_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (sum_w[WIDTH-1] != bus_a[WIDTH-1]);
            end
            OP_AND:  alu_res = bus_a & bus_b;
            OP_OR:   alu_res = bus_a | bus_b;
            OP_XOR:  alu_res = bus_a ^ bus_b;
            OP_NOR:  alu_res = ~(bus_a | bus_b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus_a) < $signed(bus_b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus_a < bus_b};
            OP_SLL:  alu_res = bus_a << shamt;
            OP_SRL:  alu_res = bus_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(bus_a) >>> shamt);
            default: alu_res = '0;
         endcase
      end
   end

   // Control FSM: acceptance and result loading.
   always_comb begin
      state_d     = state_q;
      ready_c     = 1'b0;
      take_single = 1'b0;
      take_mul    = 1'b0;
      mul_start   = 1'b0;
      case (state_q)
         ST_IDLE: ready_c = 1'b1;
         ST_MUL_RUN: begin
            if (mul_done) begin
               take_mul = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            ready_c = out_ready;
            if (out_ready && !in_valid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      ready_c = ready_c & ~mul_busy;
      if (in_valid && ready_c) begin
         if (op_e == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL_RUN;
         end else begin
            take_single = 1'b1;
            state_d     = ST_DONE;
         end
      end
   end

   always_comb begin
      out_d   = out_q;
      flags_d = flags_q;
      if (take_single) begin
         out_d   = alu_res;
         flags_d = '{zero: (alu_res == '0), negative: alu_res[WIDTH-1],
                     carryout: alu_c, overflow: alu_v};
      end else if (take_mul) begin
         out_d   = mul_product[WIDTH-1:0];
         flags_d = '{zero: (mul_product[WIDTH-1:0] == '0),
                     negative: mul_product[WIDTH-1],
                     carryout: |mul_product[2*WIDTH-1:WIDTH], overflow: 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         out_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         flags_q <= flags_d;
      end
   end

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (bus_a),
      .b       (bus_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Held low through reset even though the state register reads IDLE.
   assign in_ready  = ready_c & rst_n;
   assign out_valid = (state_q == ST_DONE);
   assign out       = out_q;
   assign zero      = flags_q.zero;
   assign negative  = flags_q.negative;
   assign carryout  = flags_q.carryout;
   assign overflow  = flags_q.overflow;

endmodule
